reg_writeback: RTL
==================

# reg_writeback

Writeback arbiter and scoreboard for the pipelined core. It merges completions from the ALU pipe and the load pipe onto the single register-file write port (RegWrite, Rd, WriteData). It buffers load results that lose arbitration in a small FIFO. It also tracks which destination registers still have a write pending, so issue logic can stall on read-after-write hazards.

## Interface
Parameters:
- DEPTH, 4: load-result FIFO entries (power of two, ≥2).

Ports:
- Clk  input  1  rising-edge clock.
- Reset  input  1  asynchronous, active-high reset.
- IssueValid  input  1  an instruction with a destination register is issued this cycle.
- IssueRd  input  5  destination register of the issued instruction.
- AluValid  input  1  ALU result present this cycle; no backpressure, always accepted.
- AluRd  input  5  ALU destination register.
- AluData  input  32  ALU result.
- LoadValid  input  1  load result offered.
- LoadRd  input  5  load destination register.
- LoadData  input  32  load result.
- LoadReady  output  1  load result accepted when LoadValid && LoadReady.
- RegWrite  output  1  registered write enable to the register file.
- Rd  output  5  registered write address.
- WriteData  output  32  registered write data.
- Busy  output  32  scoreboard: bit r=1 means a write to register r is pending.
- Idle  output  1  FIFO empty, RegWrite=0, and Busy all zero.

## Operation
- Load FIFO:
  - Occupancy count is 0..DEPTH, with wrap-around read/write pointers.
  - LoadReady = (count < DEPTH), derived combinationally from registered count only.
  - When full, LoadReady=0 even if a pop occurs the same cycle.
- Per-edge selection, in priority order:
  1. AluValid=1: ALU result drives the outputs next cycle. An accepted load is pushed to the FIFO.
  2. Else FIFO non-empty: the FIFO head is popped to the outputs. An accepted load is pushed in the same cycle, so count is unchanged.
  3. Else an accepted load bypasses the FIFO straight to the outputs.
  4. Else RegWrite=0 next cycle; Rd and WriteData hold their values.
- Register 0 handling:
  - A selected write with Rd=0 is consumed (popped or accepted) but produces RegWrite=0.
  - Busy[0] is constantly 0. IssueRd=0 sets nothing.
- Ordering: ALU writes may overtake buffered loads. Issue logic must not allow two in-flight producers of the same register across pipes. This block does not reorder-check.
- Scoreboard:
  - Busy[IssueRd] is set at the edge where IssueValid=1.
  - Busy[Rd] is cleared at the edge where RegWrite=1, which is the register file's write edge.
  - Set and clear of the same bit on the same edge: set wins.
- Reset (asynchronous, any time, including with the FIFO partially full):
  - FIFO emptied, pointers=0, count=0.
  - RegWrite=0, Rd=0, WriteData=0, Busy=0.
  - Outputs after reset: LoadReady=1, Idle=1.
  - All buffered results are discarded.

## Timing
- ALU result sampled at edge N:
  - RegWrite/Rd/WriteData valid during cycle N..N+1.
  - The register file writes at edge N+1.
  - Busy clears at edge N+1.
- Load latency: 1 cycle minimum (bypass), plus one cycle per queued entry ahead, plus one per ALU cycle that wins arbitration.
- Continuous AluValid=1 starves the FIFO. The FIFO fills after DEPTH accepted loads, then LoadReady drops the following cycle.
- Busy reflects state after the last edge. A consumer sees Busy[r]=0 in the same cycle the register file holds the new value.
- No combinational path from any input to any output.

## Test plan
- Reset mid-traffic:
  - Stimulus: fill the FIFO with 3 loads while AluValid=1, then assert Reset asynchronously between edges.
  - Response: immediately RegWrite=0, Busy=0, LoadReady=1, Idle=1.
  - After release, no stale writes appear.
- Bypass:
  - Stimulus: IssueValid with IssueRd=5 at edge 0; LoadValid with LoadRd=5, LoadData=0xDEADBEEF at edge 2, FIFO empty, AluValid=0.
  - Response: RegWrite=1, Rd=5, WriteData=0xDEADBEEF in cycle 2..3.
  - Busy[5]=1 from edge 0 until edge 3.
- Collision:
  - Stimulus: AluValid (Rd=3, 0x11) and LoadValid (Rd=4, 0x22) at the same edge.
  - Response: the Rd=3 write comes first, then the Rd=4 write on the next cycle, with no gap.
- Full FIFO:
  - Stimulus: AluValid=1 for 8 cycles while loads are offered every cycle.
  - Response: exactly DEPTH=4 loads accepted and LoadReady=0 thereafter.
  - After AluValid drops, 4 load writes drain in order and LoadReady rises after the first pop cycle.
- Register 0:
  - Stimulus: AluValid with AluRd=0, AluData=0xFFFFFFFF; IssueValid with IssueRd=0.
  - Response: RegWrite stays 0, Busy[0] stays 0, and Idle returns to 1.
- Set/clear race:
  - Stimulus: IssueValid with IssueRd=7 on the same edge that RegWrite=1, Rd=7 is written.
  - Response: Busy[7] remains 1.

Source files
------------

// File: rtl/reg_writeback.sv
// Writeback arbiter: merges ALU and load completions onto one register-file
// write port, buffers losing loads in a FIFO and tracks pending destinations.
module reg_writeback #(
   parameter int DEPTH = 4
) (
   input  logic        Clk,
   input  logic        Reset,
   input  logic        IssueValid,
   input  logic [4:0]  IssueRd,
   input  logic        AluValid,
   input  logic [4:0]  AluRd,
   input  logic [31:0] AluData,
   input  logic        LoadValid,
   input  logic [4:0]  LoadRd,
   input  logic [31:0] LoadData,
   output logic        LoadReady,
   output logic        RegWrite,
   output logic [4:0]  Rd,
   output logic [31:0] WriteData,
   output logic [31:0] Busy,
   output logic        Idle
);

   localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CW = $clog2(DEPTH + 1);

   logic [36:0]   mem_q [DEPTH];
   logic [PW-1:0] wr_ptr_q, wr_ptr_d;
   logic [PW-1:0] rd_ptr_q, rd_ptr_d;
   logic [CW-1:0] count_q, count_d;
   logic          reg_write_q, reg_write_d;
   logic [4:0]    rd_q, rd_d;
   logic [31:0]   write_data_q, write_data_d;
   logic [31:0]   busy_q, busy_d;

   logic          fifo_empty;
   logic          load_acc;
   logic          push;
   logic          pop;
   logic          sel_valid;
   logic [4:0]    sel_rd;
   logic [31:0]   sel_data;
   logic [36:0]   head;

   assign fifo_empty = (count_q == '0);
   assign LoadReady  = (count_q < CW'(DEPTH));
   assign load_acc   = LoadValid && LoadReady;
   assign head       = mem_q[rd_ptr_q];

   // ALU always wins; otherwise the oldest buffered load, otherwise a bypassing load
   always_comb begin
      sel_valid = 1'b0;
      sel_rd    = AluRd;
      sel_data  = AluData;
      push      = 1'b0;
      pop       = 1'b0;
      if (AluValid) begin
         sel_valid = 1'b1;
         push      = load_acc;
      end else if (!fifo_empty) begin
         sel_valid = 1'b1;
         sel_rd    = head[36:32];
         sel_data  = head[31:0];
         pop       = 1'b1;
         push      = load_acc;
      end else if (load_acc) begin
         sel_valid = 1'b1;
         sel_rd    = LoadRd;
         sel_data  = LoadData;
      end
   end

   always_comb begin
      wr_ptr_d     = push ? wr_ptr_q + PW'(1) : wr_ptr_q;
      rd_ptr_d     = pop  ? rd_ptr_q + PW'(1) : rd_ptr_q;
      count_d      = count_q + CW'(push) - CW'(pop);
      reg_write_d  = sel_valid && (sel_rd != 5'd0);
      rd_d         = reg_write_d ? sel_rd   : rd_q;
      write_data_d = reg_write_d ? sel_data : write_data_q;
   end

   // Clear applies first so a same-edge issue to the written register keeps it busy
   always_comb begin
      busy_d = busy_q;
      if (reg_write_q) begin
         busy_d[rd_q] = 1'b0;
      end
      if (IssueValid) begin
         busy_d[IssueRd] = 1'b1;
      end
      busy_d[0] = 1'b0;
   end

   always_ff @(posedge Clk or posedge Reset) begin
      if (Reset) begin
         wr_ptr_q     <= '0;
         rd_ptr_q     <= '0;
         count_q      <= '0;
         reg_write_q  <= 1'b0;
         rd_q         <= '0;
         write_data_q <= '0;
         busy_q       <= '0;
      end else begin
         wr_ptr_q     <= wr_ptr_d;
         rd_ptr_q     <= rd_ptr_d;
         count_q      <= count_d;
         reg_write_q  <= reg_write_d;
         rd_q         <= rd_d;
         write_data_q <= write_data_d;
         busy_q       <= busy_d;
      end
   end

   // Storage needs no reset: the pointers and count define what is valid
   always_ff @(posedge Clk) begin
      if (push) begin
         mem_q[wr_ptr_q] <= {LoadRd, LoadData};
      end
   end

   assign RegWrite  = reg_write_q;
   assign Rd        = rd_q;
   assign WriteData = write_data_q;
   assign Busy      = busy_q;
   assign Idle      = fifo_empty && !reg_write_q && (busy_q == '0);

endmodule
